// File: rtl/tpu_job_sequencer.sv
// -----------------------------------------------------------------------------
// tpu_job_sequencer
//
// Host-side command sequencer for the tpuv1 memory-mapped port.
//
// It takes one matrix job as a stream of DATAW words: DIM A rows, then DIM
// B rows. It turns that job into tpuv1 bus writes in this order:
//   - A rows
//   - B rows
//   - a clear of every C half-row
//   - a start write
// It then waits for the systolic array, reads every C half-row back, and
// returns the half-rows on an output valid/ready stream.
//
// Address map (tpu_addr):
//   A row r        : 0x100 + 8*r
//   B row r        : 0x200 + 8*r
//   C row r, half h: 0x300 + 16*r + 8*h
//   start          : 0x400
//   idle           : 0x000
//
// Optional feature, selected by the TPU_SEQ_ACCUM_EN macro:
//   When defined, a job started with accum=1 skips the C clear. The new
//   product then accumulates onto the previous job's result. When the macro
//   is not defined, the accum port is present but ignored.
//
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   job_start  one-cycle pulse; begins a job when idle
//   accum      keep existing C contents (TPU_SEQ_ACCUM_EN builds only)
//   in_valid   input word valid
//   in_ready   sequencer accepts input word
//   in_data    A rows (DIM words) then B rows (DIM words)
//   out_valid  result word valid
//   out_ready  consumer accepts result word
//   out_data   C half-row, 4 x BITS_C, element 0 in the LSBs
//   busy       high from the cycle after an accepted job_start until DONE exits
//   done       one-cycle pulse after the last result is accepted
//   tpu_addr   tpuv1 address (registered)
//   tpu_r_w    tpuv1 read/write, 1 = write (registered)
//   tpu_dout   tpuv1 write data (registered)
//   tpu_din    tpuv1 read data, combinational from tpu_addr
// -----------------------------------------------------------------------------
module tpu_job_sequencer #(
  parameter int BITS_AB     = 8,
  parameter int BITS_C      = 16,
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int WAIT_CYCLES = 3*DIM+2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_start,
  input  logic             accum,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DATAW-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] tpu_addr,
  output logic             tpu_r_w,
  output logic [DATAW-1:0] tpu_dout,
  input  logic [DATAW-1:0] tpu_din
);

  localparam int CW       = $clog2(2*DIM) + 1;
  localparam int WW       = $clog2(WAIT_CYCLES + 1);
  localparam int ROW_BITS = DIM * BITS_AB;
  // Number of DATAW-wide half-rows that hold the whole C matrix.
  localparam int C_WORDS  = (DIM * DIM * BITS_C) / DATAW;

  localparam logic [ADDRW-1:0] A_BASE     = ADDRW'(32'h100);
  localparam logic [ADDRW-1:0] B_BASE     = ADDRW'(32'h200);
  localparam logic [ADDRW-1:0] C_BASE     = ADDRW'(32'h300);
  localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(32'h400);

  localparam logic [CW-1:0] LAST_ROW = CW'(DIM - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(C_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLR_C,
    START,
    WAIT,
    READ_C,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [DATAW-1:0] row_word;
  logic             skip_clear;

  // A and B rows use DIM*BITS_AB bits. Any bits above that are forced to zero.
  assign row_word = DATAW'(in_data[ROW_BITS-1:0]);

  // Every tpuv1 region uses an 8-byte stride per DATAW word.
  function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                 input logic [CW-1:0]    idx);
    return base + (ADDRW'(idx) << 3);
  endfunction

`ifdef TPU_SEQ_ACCUM_EN
  logic accum_flag;

  // accum is only meaningful at the moment a job is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      accum_flag <= 1'b0;
    end else if (state == IDLE && job_start) begin
      accum_flag <= accum;
    end
  end

  assign skip_clear = accum_flag;
`else
  logic unused_accum;

  assign unused_accum = accum;
  assign skip_clear   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      wait_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tpu_addr  <= '0;
      tpu_r_w   <= 1'b0;
      tpu_dout  <= '0;
    end else begin
      // NOTE: state and registered outputs use non-blocking assignments only.
      // That lets the idle-bus defaults below be overridden later in the same
      // block without any ordering hazard.
      tpu_addr <= '0;
      tpu_r_w  <= 1'b0;
      tpu_dout <= '0;
      done     <= 1'b0;

      case (state)
        IDLE: begin
          if (job_start) begin
            state    <= LOAD_A;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            beat_cnt <= '0;
          end
        end

        LOAD_A: begin
          if (in_valid && in_ready) begin
            tpu_addr <= word_addr(A_BASE, beat_cnt);
            tpu_r_w  <= 1'b1;
            tpu_dout <= row_word;
            if (beat_cnt == LAST_ROW) begin
              state    <= LOAD_B;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end

        LOAD_B: begin
          if (in_valid && in_ready) begin
            tpu_addr <= word_addr(B_BASE, beat_cnt);
            tpu_r_w  <= 1'b1;
            tpu_dout <= row_word;
            if (beat_cnt == LAST_ROW) begin
              state    <= skip_clear ? START : CLR_C;
              in_ready <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end

        CLR_C: begin
          // One zero write per cycle. tpu_dout already defaults to zero.
          tpu_addr <= word_addr(C_BASE, beat_cnt);
          tpu_r_w  <= 1'b1;
          if (beat_cnt == LAST_C) begin
            state    <= START;
            beat_cnt <= '0;
          end else begin
            beat_cnt <= beat_cnt + CW'(1);
          end
        end

        START: begin
          tpu_addr <= START_ADDR;
          tpu_r_w  <= 1'b1;
          wait_cnt <= WW'(WAIT_CYCLES);
          state    <= WAIT;
        end

        WAIT: begin
          if (wait_cnt == '0) begin
            // Present the first C address so its data is ready next cycle.
            state    <= READ_C;
            beat_cnt <= '0;
            tpu_addr <= C_BASE;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end

        READ_C: begin
          // The read address stays put until the current word is accepted.
          // out_data therefore always matches tpu_addr while out_valid is high.
          tpu_addr <= tpu_addr;
          if (!out_valid) begin
            out_data  <= tpu_din;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (beat_cnt == LAST_C) begin
              state    <= DONE;
              done     <= 1'b1;
              beat_cnt <= '0;
              tpu_addr <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
              tpu_addr <= word_addr(C_BASE, beat_cnt + CW'(1));
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_tpu_job_sequencer
//
// Self-checking bench for tpu_job_sequencer.
//
// A small tpuv1 model sits on the bus:
//   - It stores the A and B rows it is sent.
//   - It stores the C half-row writes.
//   - On the start write it performs C += A*B.
//   - It returns C half-rows combinationally from tpu_addr.
//
// Each job is described by two tables:
//   - ld_tbl: input words paired with the bus write each one must produce.
//   - rd_tbl: result words paired with the C address each one must sit on.
// Expected results are written out by hand for each stimulus pattern.
// -----------------------------------------------------------------------------
module tb_tpu_job_sequencer;

  localparam int DIM = 8;
  localparam int NW  = 2 * DIM;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        job_start;
  logic        accum;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic        done;
  logic [15:0] tpu_addr;
  logic        tpu_r_w;
  logic [63:0] tpu_dout;
  logic [63:0] tpu_din;

  tpu_job_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .job_start (job_start),
    .accum     (accum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .tpu_addr  (tpu_addr),
    .tpu_r_w   (tpu_r_w),
    .tpu_dout  (tpu_dout),
    .tpu_din   (tpu_din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [15:0] addr;
  } vec_t;

  vec_t ld_tbl [NW];
  vec_t rd_tbl [NW];

  int    n_cmp    = 0;
  int    n_fail   = 0;
  int    done_cnt = 0;
  bit    saw_start = 1'b0;
  string cur_test = "init";

  logic [15:0] wlog_addr [$];
  logic [63:0] wlog_data [$];

  logic [63:0] a_mem [DIM];
  logic [63:0] b_mem [DIM];
  logic [15:0] c_mem [DIM][DIM];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL [%s] %s: actual=%0h required=%0h", cur_test, name, act, exp);
    end
  endtask

  // ---------------- tpuv1 model ----------------
  always_comb begin
    tpu_din = '0;
    if (tpu_addr[15:8] == 8'h03)
      for (int e = 0; e < 4; e++)
        tpu_din[16*e +: 16] = c_mem[tpu_addr[6:4]][4*int'(tpu_addr[3]) + e];
  end

  task automatic tpu_matmul();
    int s;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        s = int'(c_mem[i][j]);
        for (int k = 0; k < DIM; k++)
          s += int'(a_mem[i][8*k +: 8]) * int'(b_mem[k][8*j +: 8]);
        c_mem[i][j] = 16'(s);
      end
  endtask

  // The bus is sampled mid-cycle. Each logged entry is one write cycle.
  initial begin
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        c_mem[i][j] = '0;
    forever begin
      @(negedge clk);
      if (tpu_r_w === 1'b1) begin
        wlog_addr.push_back(tpu_addr);
        wlog_data.push_back(tpu_dout);
        case (tpu_addr[15:8])
          8'h01: a_mem[tpu_addr[5:3]] = tpu_dout;
          8'h02: b_mem[tpu_addr[5:3]] = tpu_dout;
          8'h03: for (int e = 0; e < 4; e++)
                   c_mem[tpu_addr[6:4]][4*int'(tpu_addr[3]) + e] = tpu_dout[16*e +: 16];
          8'h04: begin
            saw_start = 1'b1;
            tpu_matmul();
          end
          default: ;
        endcase
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  // ---------------- stimulus tables ----------------
  // pat 0: A = identity, B row r = r+1 in every byte  -> C[r][j] = r+1
  // pat 1: A = all ones, B as pat 0                   -> C[r][j] = 1+..+8 = 36
  // pat 2: A = identity, B row r byte j = 8r+j        -> C[r][j] = 8r+j
  // pat 3: loads as pat 0, C accumulated twice        -> C[r][j] = 2(r+1)
  task automatic fill_tables(input int pat);
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    int v;
    for (int r = 0; r < DIM; r++) begin
      a = (pat == 1) ? 64'h0101_0101_0101_0101 : (64'h1 << (8*r));
      for (int j = 0; j < DIM; j++)
        b[8*j +: 8] = (pat == 2) ? 8'(8*r + j) : 8'(r + 1);
      ld_tbl[r].data       = a;
      ld_tbl[r].addr       = 16'(32'h100 + 8*r);
      ld_tbl[DIM + r].data = b;
      ld_tbl[DIM + r].addr = 16'(32'h200 + 8*r);
      for (int h = 0; h < 2; h++) begin
        for (int e = 0; e < 4; e++) begin
          case (pat)
            1:       v = 36;
            2:       v = 8*r + 4*h + e;
            3:       v = 2*(r + 1);
            default: v = r + 1;
          endcase
          w[16*e +: 16] = 16'(v);
        end
        rd_tbl[2*r + h].data = w;
        rd_tbl[2*r + h].addr = 16'(32'h300 + 16*r + 8*h);
      end
    end
  endtask

  // ---------------- job phases (each starts and ends at posedge+1) ----------------
  task automatic check_idle_outputs();
    check("idle_in_ready",  64'(in_ready),  64'd0);
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_busy",      64'(busy),      64'd0);
    check("idle_done",      64'(done),      64'd0);
    check("idle_r_w",       64'(tpu_r_w),   64'd0);
    check("idle_addr",      64'(tpu_addr),  64'd0);
    check("idle_dout",      tpu_dout,       64'd0);
    check("idle_out_data",  out_data,       64'd0);
  endtask

  task automatic start_job(input bit acc);
    wlog_addr.delete();
    wlog_data.delete();
    saw_start = 1'b0;
    job_start = 1'b1;
    accum     = acc;
    @(negedge clk);
    check("busy_before_start", 64'(busy), 64'd0);
    check("in_ready_idle",     64'(in_ready), 64'd0);
    @(posedge clk); #1;
    job_start = 1'b0;
    accum     = 1'b0;
    @(negedge clk);
    check("busy_after_start",  64'(busy), 64'd1);
    check("in_ready_load_a",   64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic load_words(input bit toggle);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < NW && cyc < 200) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data  = ld_tbl[idx].data;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    check("load_beats", 64'(idx), 64'(NW));
    @(negedge clk);
    check("in_ready_after_load", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic collect_results(input int stall_word, input bit pulse);
    int n      = 0;
    int held   = 0;
    int budget = 400;
    int d0     = done_cnt;
    bit pulsed = 1'b0;
    while (n < NW && budget > 0) begin
      out_ready = !(n == stall_word && held < 5);
      job_start = pulse && n == 5 && !pulsed;
      if (job_start) pulsed = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        check($sformatf("res_addr[%0d]", n), 64'(tpu_addr), 64'(rd_tbl[n].addr));
        check($sformatf("res_data[%0d]", n), out_data, rd_tbl[n].data);
        if (out_ready) n++;
        else held++;
      end
      @(posedge clk); #1;
      budget--;
    end
    out_ready = 1'b1;
    job_start = 1'b0;
    check("result_count", 64'(n), 64'(NW));
    if (stall_word >= 0) check("stall_cycles", 64'(held), 64'd5);
    @(negedge clk);
    check("done_pulse",   64'(done), 64'd1);
    check("busy_in_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_clears",     64'(done),     64'd0);
    check("busy_after_done", 64'(busy),     64'd0);
    check("in_ready_idle",   64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("done_count", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic check_log(input bit exp_clear);
    int exp_n = exp_clear ? 2*NW + 1 : NW + 1;
    int n3 = 0;
    for (int i = 0; i < wlog_addr.size(); i++)
      if (wlog_addr[i][15:8] == 8'h03) n3++;
    check("write_count",    64'(wlog_addr.size()), 64'(exp_n));
    check("c_clear_writes", 64'(n3), exp_clear ? 64'(NW) : 64'd0);
    if (wlog_addr.size() == exp_n) begin
      for (int i = 0; i < NW; i++) begin
        check($sformatf("ld_addr[%0d]", i), 64'(wlog_addr[i]), 64'(ld_tbl[i].addr));
        check($sformatf("ld_data[%0d]", i), wlog_data[i], ld_tbl[i].data);
      end
      if (exp_clear)
        for (int i = 0; i < NW; i++) begin
          check($sformatf("clr_addr[%0d]", i), 64'(wlog_addr[NW + i]), 64'(32'h300 + 8*i));
          check($sformatf("clr_data[%0d]", i), wlog_data[NW + i], 64'd0);
        end
      check("start_addr", 64'(wlog_addr[exp_n - 1]), 64'h400);
      check("start_data", wlog_data[exp_n - 1], 64'd0);
    end
  endtask

  task automatic run_job(input bit toggle, input int stall_word, input bit acc,
                         input bit pulse, input bit exp_clear);
    start_job(acc);
    load_words(toggle);
    collect_results(stall_word, pulse);
    check_log(exp_clear);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int cyc;
    rst_n     = 1'b0;
    job_start = 1'b0;
    accum     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cur_test = "reset";
    @(negedge clk);
    check_idle_outputs();
    @(posedge clk); #1;

    cur_test = "identity";
    fill_tables(0);
    run_job(1'b0, -1, 1'b0, 1'b0, 1'b1);

    cur_test = "valid_toggle";
    fill_tables(1);
    run_job(1'b1, -1, 1'b0, 1'b0, 1'b1);

    cur_test = "out_stall";
    fill_tables(2);
    run_job(1'b0, 3, 1'b0, 1'b0, 1'b1);

    cur_test = "reset_in_wait";
    fill_tables(0);
    start_job(1'b0);
    load_words(1'b0);
    cyc = 0;
    while (!saw_start && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("start_seen", 64'(saw_start), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs();
    wlog_addr.delete();
    wlog_data.delete();
    repeat (40) @(posedge clk);
    #1;
    check("no_bus_after_reset",   64'(wlog_addr.size()), 64'd0);
    check("no_result_after_reset", 64'(out_valid), 64'd0);

    cur_test = "start_in_read";
    fill_tables(2);
    run_job(1'b0, -1, 1'b0, 1'b1, 1'b1);

`ifdef TPU_SEQ_ACCUM_EN
    cur_test = "accum_job1";
    fill_tables(0);
    run_job(1'b0, -1, 1'b0, 1'b0, 1'b1);
    cur_test = "accum_job2";
    fill_tables(3);
    run_job(1'b0, -1, 1'b1, 1'b0, 1'b0);
`else
    cur_test = "accum_ignored";
    fill_tables(0);
    run_job(1'b0, -1, 1'b1, 1'b0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL [%s] watchdog: actual=timeout required=finish", cur_test);
    $fatal(1, "watchdog expired");
  end

endmodule
